mq_byteout_ctrl: RTL and testbench

MQ_BYTEOUT_CTRL -- requirements
Module: mq_byteout_ctrl

---
 rtl/mq_byteout_ctrl.sv | 139 +++++++++++++
 tb/tb_mq_byteout_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mq_byteout_ctrl.sv
// MQ coder byte-out controller: holds one pending byte B so a later carry can
// still ripple into it, requests bit stuffing after 0xFF, and terminates on flush.
module mq_byteout_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        carry_in,
  output logic        byte_ready,
  output logic        stuff_next,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [15:0] byte_count,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  b_r, b_s;
  logic        out_valid_r, out_valid_s;
  logic [7:0]  out_data_r, out_data_s;
  logic        flush_done_r, flush_done_s;
  logic [15:0] byte_count_r, byte_count_s;
  logic        err_r, err_s;
  logic        slot_free_s, drain_s, accept_s, carry_eff_s;

  assign slot_free_s = !out_valid_r || out_ready;
  assign drain_s     = out_valid_r && out_ready;
  assign byte_ready  = (state_r == ST_EMPTY) || ((state_r == ST_HOLD) && slot_free_s);
  assign stuff_next  = (state_r == ST_HOLD) &&
                       ((b_r == 8'hFF) || ((b_r == 8'hFE) && carry_in));
  // A flush request always beats a byte presented in the same cycle.
  assign accept_s    = byte_valid && byte_ready && !flush_req;
  // A carry cannot propagate past 0xFF (the stuffed bit absorbs it).
  assign carry_eff_s = carry_in && (b_r != 8'hFF);

  assign flush_done = flush_done_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign byte_count = byte_count_r;
  assign err        = err_r;

  // Next-state, pending-byte, output-slot, counter and error logic.
  always_comb begin
    state_s      = state_r;
    b_s          = b_r;
    out_valid_s  = out_valid_r && !out_ready;
    out_data_s   = out_data_r;
    flush_done_s = 1'b0;
    err_s        = err_r;
    if (drain_s && (byte_count_r != 16'hFFFF)) begin
      byte_count_s = byte_count_r + 16'd1;
    end else begin
      byte_count_s = byte_count_r;
    end

    case (state_r)
      ST_EMPTY: begin
        if (flush_req) begin
          state_s      = ST_DONE;
          flush_done_s = 1'b1;
          err_s        = err_r | byte_valid;
        end else if (accept_s) begin
          b_s     = byte_in;
          state_s = ST_HOLD;
          err_s   = err_r | carry_in;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (flush_req) begin
          err_s = err_r | byte_valid;
          if (b_r == 8'hFF) begin
            state_s      = ST_DONE;
            flush_done_s = 1'b1;
          end else begin
            state_s = ST_FLUSH;
          end
        end else if (accept_s) begin
          out_data_s  = b_r + {7'd0, carry_eff_s};
          out_valid_s = 1'b1;
          b_s         = byte_in;
          err_s       = err_r | (carry_in && (b_r == 8'hFF));
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_FLUSH: begin
        if (slot_free_s) begin
          out_data_s   = b_r;
          out_valid_s  = 1'b1;
          state_s      = ST_DONE;
          flush_done_s = 1'b1;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_s      = ST_EMPTY;
        byte_count_s = 16'd0;
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      b_r          <= 8'd0;
      out_valid_r  <= 1'b0;
      out_data_r   <= 8'd0;
      flush_done_r <= 1'b0;
      byte_count_r <= 16'd0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      b_r          <= b_s;
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      flush_done_r <= flush_done_s;
      byte_count_r <= byte_count_s;
      err_r        <= err_s;
    end
  end

endmodule

// File: tb/tb_mq_byteout_ctrl.sv
// Directed plus randomized bench for mq_byteout_ctrl, checked every cycle
// against a behavioural model of the pending-byte / output-slot protocol.
module tb_mq_byteout_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        carry_in = 1'b0;
  logic        flush_req = 1'b0;
  logic        out_ready = 1'b1;
  logic        byte_ready, stuff_next, flush_done, out_valid, err;
  logic [7:0]  out_data;
  logic [15:0] byte_count;

  mq_byteout_ctrl dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in),
    .carry_in(carry_in), .byte_ready(byte_ready), .stuff_next(stuff_next),
    .flush_req(flush_req), .flush_done(flush_done), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .byte_count(byte_count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = accepting bytes, 1 = final push pending, 2 = terminating.
  bit         m_have;
  logic [7:0] m_b;
  int         m_ph;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_fd;
  int         m_cnt;
  bit         m_err;

  logic [7:0] obs[$];
  logic       s_ready, s_stuff, s_fd, s_err, s_ov;
  logic [7:0] s_od;
  logic [15:0] s_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic bit exp_ready();
    return (m_ph == 0) && (!m_have || !m_ov || out_ready);
  endfunction

  function automatic bit exp_stuff();
    return (m_ph == 0) && m_have && ((m_b == 8'hFF) || ((m_b == 8'hFE) && carry_in));
  endfunction

  task automatic model_step();
    bit         nov, c;
    logic [7:0] nod;
    int         nph;
    if (rst) begin
      m_have = 0; m_b = 8'd0; m_ph = 0; m_ov = 0; m_od = 8'd0;
      m_fd = 0; m_cnt = 0; m_err = 0;
    end else begin
      nov = m_ov && !out_ready;
      nod = m_od;
      nph = m_ph;
      if (m_ov && out_ready && m_cnt < 65535) m_cnt++;
      case (m_ph)
        0: begin
          if (flush_req) begin
            if (byte_valid) m_err = 1;
            if (m_have && m_b != 8'hFF) nph = 1;
            else begin nph = 2; m_have = 0; end
          end else if (byte_valid && exp_ready()) begin
            if (!m_have) begin
              if (carry_in) m_err = 1;
              m_b = byte_in;
              m_have = 1;
            end else begin
              c = carry_in;
              if (m_b == 8'hFF && c) begin m_err = 1; c = 0; end
              nod = m_b + {7'd0, c};
              nov = 1;
              m_b = byte_in;
            end
          end
        end
        1: begin
          if (!m_ov || out_ready) begin
            nod = m_b; nov = 1; m_have = 0; nph = 2;
          end
        end
        default: begin nph = 0; m_cnt = 0; end
      endcase
      m_ov = nov;
      m_od = nod;
      m_fd = (nph == 2);
      m_ph = nph;
    end
  endtask

  task automatic cycle(input logic r, input logic bv, input logic [7:0] bi,
                       input logic c, input logic fr, input logic ordy);
    @(negedge clk);
    rst = r; byte_valid = bv; byte_in = bi; carry_in = c; flush_req = fr; out_ready = ordy;
    #1;
    s_ready = byte_ready; s_stuff = stuff_next; s_fd = flush_done; s_err = err;
    s_ov = out_valid; s_od = out_data; s_cnt = byte_count;
    chk("byte_ready", {31'd0, byte_ready}, {31'd0, exp_ready()});
    chk("stuff_next", {31'd0, stuff_next}, {31'd0, exp_stuff()});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data", {24'd0, out_data}, {24'd0, m_od});
    chk("flush_done", {31'd0, flush_done}, {31'd0, m_fd});
    chk("byte_count", {16'd0, byte_count}, m_cnt);
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (out_valid && out_ready) obs.push_back(out_data);
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    obs.delete();
  endtask

  task automatic push(input logic [7:0] bi, input logic c);
    cycle(1'b0, 1'b1, bi, c, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    logic [7:0] bi;
    // Basic stream and flush of a normal pending byte.
    do_reset();
    chk("reset_count", {16'd0, s_cnt}, 32'd0);
    chk("reset_valid", {31'd0, s_ov}, 32'd0);
    push(8'h12, 1'b0);
    push(8'h34, 1'b0);
    push(8'h56, 1'b0);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("flush_done_pulse", {31'd0, s_fd}, 32'd1);
    idle(1'b1);
    chk("count_cleared", {16'd0, s_cnt}, 32'd0);
    chk("flush_done_single", {31'd0, s_fd}, 32'd0);
    chk("stream_len", obs.size(), 32'd3);
    if (obs.size() == 3) begin
      chk("stream_b0", {24'd0, obs[0]}, 32'h12);
      chk("stream_b1", {24'd0, obs[1]}, 32'h34);
      chk("stream_b2", {24'd0, obs[2]}, 32'h56);
    end

    // Carry into 0x7F.
    do_reset();
    push(8'h7F, 1'b0);
    push(8'h00, 1'b1);
    chk("carry7f_stuff", {31'd0, s_stuff}, 32'd0);
    idle(1'b1);
    chk("carry7f_out", {24'd0, obs.size() > 0 ? obs[0] : 8'hxx}, 32'h80);

    // Carry into 0xFE forces stuffing.
    do_reset();
    push(8'hFE, 1'b0);
    push(8'h11, 1'b1);
    chk("carryfe_stuff", {31'd0, s_stuff}, 32'd1);
    idle(1'b1);
    chk("carryfe_out", {24'd0, obs.size() > 0 ? obs[0] : 8'hxx}, 32'hFF);

    // Pending 0xFF is discarded on flush.
    do_reset();
    push(8'hFF, 1'b0);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("ff_flush_done", {31'd0, s_fd}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("ff_no_push", obs.size(), 32'd0);

    // Backpressure for 5 cycles.
    do_reset();
    cycle(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
      chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
      chk("bp_data_stable", {24'd0, s_od}, 32'hAA);
    end
    push(8'hCC, 1'b0);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("bp_len", obs.size(), 32'd3);
    if (obs.size() == 3) begin
      chk("bp_b0", {24'd0, obs[0]}, 32'hAA);
      chk("bp_b1", {24'd0, obs[1]}, 32'hBB);
      chk("bp_b2", {24'd0, obs[2]}, 32'hCC);
    end

    // Carry in EMPTY is a sticky error.
    do_reset();
    push(8'h01, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("err_carry_empty", {31'd0, s_err}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, s_err}, 32'd0);

    // Flush colliding with a byte in HOLD.
    push(8'h21, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("err_flush_collide", {31'd0, s_err}, 32'd1);

    // Reset while a flush is blocked by backpressure.
    do_reset();
    cycle(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("rst_flush_no_done", {31'd0, s_fd}, 32'd0);
    chk("rst_flush_no_valid", {31'd0, s_ov}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: bi = 8'hFF;
        1: bi = 8'hFE;
        default: bi = 8'($urandom_range(0, 255));
      endcase
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), bi,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
